// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default framing parameters
// and the counter width helper used by the transmit and receive paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_DATA_BITS    = 8;

    // Never returns zero, so a counter always has at least one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter producing a terminal-count pulse once per bit period;
// reloads itself on terminal count while enabled.
module uart_bit_timer #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] reload_val,
    output logic             tc
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= reload_val;
        end else if (en) begin
            if (cnt == '0) begin
                cnt <= reload_val;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign tc = en && (cnt == '0);

endmodule

// File: rtl/uart_tx_piso.sv
// UART transmitter: accepts a parallel word over valid/ready and shifts it out
// LSB first as start, data, optional parity and stop bits on a registered line.
//
// state  | meaning
// IDLE   | line high, ready for a new word
// START  | driving start bit (0) for one bit period
// DATA   | driving shift[0], shifting right after each bit period
// PARITY | driving the parity bit computed at accept
// STOP   | line high for STOP_BITS bit periods, then tx_done
module uart_tx_piso
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam int IDX_W = cnt_width(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] RELOAD    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS - 1);

    uart_state_t          state, state_nxt;
    logic [DATA_BITS-1:0] shift_q, shift_nxt;
    logic [IDX_W-1:0]     idx_q, idx_nxt;
    logic [1:0]           stop_q, stop_nxt;
    logic                 par_q, par_nxt;
    logic                 done_nxt;
    logic                 out_nxt;
    logic                 timer_load;
    logic                 timer_en;
    logic                 tc;

    assign timer_en = (state != IDLE);

    uart_bit_timer #(
        .WIDTH(CNT_W)
    ) u_bit_timer (
        .Clk        (Clk),
        .reset      (reset),
        .load       (timer_load),
        .en         (timer_en),
        .reload_val (RELOAD),
        .tc         (tc)
    );

    always_comb begin
        state_nxt  = state;
        shift_nxt  = shift_q;
        idx_nxt    = idx_q;
        stop_nxt   = stop_q;
        par_nxt    = par_q;
        done_nxt   = 1'b0;
        timer_load = 1'b0;
        out_nxt    = 1'b1;
        case (state)
            IDLE: begin
                if (tx_valid) begin
                    state_nxt  = START;
                    shift_nxt  = tx_data;
                    par_nxt    = (^tx_data) ^ (PARITY_ODD != 0);
                    timer_load = 1'b1;
                end
            end
            START: begin
                if (tc) begin
                    state_nxt = DATA;
                    idx_nxt   = '0;
                end
            end
            DATA: begin
                if (tc) begin
                    if (idx_q == LAST_IDX) begin
                        state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                        stop_nxt  = '0;
                    end else begin
                        idx_nxt   = idx_q + 1'b1;
                        shift_nxt = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (tc) begin
                    state_nxt = STOP;
                    stop_nxt  = '0;
                end
            end
            STOP: begin
                if (tc) begin
                    if (stop_q == LAST_STOP) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        stop_nxt = stop_q + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Line level follows the state being entered so tx_out stays a plain flop.
        case (state_nxt)
            START:   out_nxt = 1'b0;
            DATA:    out_nxt = shift_nxt[0];
            PARITY:  out_nxt = par_nxt;
            default: out_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            stop_q  <= '0;
            par_q   <= 1'b0;
            tx_out  <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            shift_q <= shift_nxt;
            idx_q   <= idx_nxt;
            stop_q  <= stop_nxt;
            par_q   <= par_nxt;
            tx_out  <= out_nxt;
            tx_busy <= (state_nxt != IDLE);
            tx_done <= done_nxt;
        end
    end

    assign tx_ready = (state == IDLE);

endmodule
